// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Purpose: shares one sequential unsigned shift-add multiplier among NUM_REQ requesters.
// Requests are granted round-robin. Each product returns on a single response channel,
// tagged with the ID of the requester that issued it.
//
// Ports:
//   sclk       - system clock, rising edge
//   s_rst_n    - asynchronous active-low reset
//   req_valid  - per-requester operand valid
//   req_ready  - per-requester accept (one-hot or zero, only in IDLE)
//   req_x      - packed multiplicands, channel i at [i*DW +: DW]
//   req_y      - packed multipliers, same packing
//   rsp_valid  - product valid
//   rsp_ready  - consumer accepts product
//   rsp_p      - unsigned product (2*DW bits)
//   rsp_id     - index of the requester that issued the product
//   busy       - high whenever the FSM is not in IDLE
//
// Optional feature: define MULT_EARLY_TERM_EN to leave CALC as soon as the shifted
// multiplier becomes zero. The product is the same; only the latency changes.
module mult_share_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned IDW     = 2
) (
   input  logic                  sclk,
   input  logic                  s_rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_x,
   input  logic [NUM_REQ*DW-1:0] req_y,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*DW-1:0]       rsp_p,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          r_state, w_state_next;
   logic [IDW-1:0]  r_rr_ptr, r_tag;
   logic [2*DW-1:0] r_x, r_acc;
   logic [DW-1:0]   r_y;
   logic [CW-1:0]   r_count;
   logic [2*DW-1:0] r_rsp_p;
   logic [IDW-1:0]  r_rsp_id;

   logic [IDW-1:0]  w_grant, w_idx;
   logic            w_found;
   logic [DW-1:0]   w_sel_x, w_sel_y;
   logic            w_accept;
   logic            w_calc_last;
   logic [DW-1:0]   w_y_shift;
   logic [2*DW-1:0] w_acc_sum;

   // Round-robin search: first valid channel at or above rr_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      w_sel_x = '0;
      w_sel_y = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
            w_sel_x = req_x[w_idx*DW +: DW];
            w_sel_y = req_y[w_idx*DW +: DW];
         end
      end
   end

   assign w_y_shift = r_y >> 1;
   assign w_acc_sum = r_y[0] ? (r_acc + r_x) : r_acc;

`ifdef MULT_EARLY_TERM_EN
   // No set bits left in the multiplier: remaining partial products are all zero.
   assign w_calc_last = (r_count == CW'(DW - 1)) || (w_y_shift == '0);
`else
   assign w_calc_last = (r_count == CW'(DW - 1));
`endif

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      w_accept     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               req_ready[w_grant] = 1'b1;
               w_accept           = 1'b1;
               w_state_next       = StCalc;
            end
         end
         StCalc: begin
            if (w_calc_last) w_state_next = StDone;
         end
         StDone: begin
            if (rsp_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_rr_ptr <= '0;
         r_tag    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_rsp_p  <= '0;
         r_rsp_id <= '0;
      end else begin
         if (w_accept) begin
            r_x      <= {{DW{1'b0}}, w_sel_x};
            r_y      <= w_sel_y;
            r_acc    <= '0;
            r_count  <= '0;
            r_tag    <= w_grant;
            r_rr_ptr <= (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
         end else if (r_state == StCalc) begin
            r_acc   <= w_acc_sum;
            r_x     <= r_x << 1;
            r_y     <= w_y_shift;
            r_count <= r_count + 1'b1;
            // Result includes this cycle's partial product.
            if (w_calc_last) begin
               r_rsp_p  <= w_acc_sum;
               r_rsp_id <= r_tag;
            end
         end
      end
   end

   assign rsp_valid = (r_state == StDone);
   assign rsp_p     = r_rsp_p;
   assign rsp_id    = r_rsp_id;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
module tb_mult_share_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DW      = 8;
   localparam int unsigned IDW     = 2;

   logic                  sclk = 1'b0;
   logic                  s_rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*DW-1:0] req_x = '0;
   logic [NUM_REQ*DW-1:0] req_y = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [2*DW-1:0]       rsp_p;
   logic [IDW-1:0]        rsp_id;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;
   int model_rr = 0;

   mult_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DW      (DW),
      .IDW     (IDW)
   ) dut (
      .sclk      (sclk),
      .s_rst_n   (s_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 sclk = ~sclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Arbitration rule: first valid channel searching upward from the pointer.
   function automatic int model_grant();
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (model_rr + k) % NUM_REQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic int exp_lat(input logic [DW-1:0] y);
`ifdef MULT_EARLY_TERM_EN
      int h;
      h = 0;
      for (int b = 0; b < DW; b++) if (y[b]) h = b + 1;
      return (h < 1) ? 1 : h;
`else
      return DW;
`endif
   endfunction

   task automatic do_reset();
      s_rst_n = 1'b0;
      repeat (2) @(negedge sclk);
      s_rst_n = 1'b1;
      model_rr = 0;
      @(negedge sclk);
   endtask

   // One complete transaction, entered and left at a falling edge.
   task automatic run_op(input int stall, input bit drop, output int gid,
                         output logic [2*DW-1:0] gp);
      int g, cyc, lat;
      logic [DW-1:0] ex, ey;
      logic [2*DW-1:0] ep, hold_p;
      logic [IDW-1:0] hold_id;
      bit bad;
      gid = -1;
      gp  = '0;
      rsp_ready = (stall == 0);
      #1;
      cyc = 0;
      while (req_ready == '0 && cyc < 50) begin
         @(negedge sclk);
         #1;
         cyc++;
      end
      check("grant_wait", 32'(req_ready != '0), 1);
      if (req_ready == '0) return;
      g = model_grant();
      check("req_ready_onehot", 32'(req_ready), (g < 0) ? 0 : (32'(1) << g));
      if (g < 0) return;
      ex = req_x[g*DW +: DW];
      ey = req_y[g*DW +: DW];
      ep = {{DW{1'b0}}, ex} * {{DW{1'b0}}, ey};
      model_rr = (g + 1) % NUM_REQ;
      @(posedge sclk);
      @(negedge sclk);
      if (drop) begin
         req_valid[g] = 1'b0;
         req_x[g*DW +: DW] = DW'($urandom);
         req_y[g*DW +: DW] = DW'($urandom);
      end
      lat = 0;
      bad = 0;
      while (!rsp_valid && lat < 4 * DW) begin
         if (busy !== 1'b1 || req_ready !== '0) bad = 1;
         @(negedge sclk);
         lat++;
      end
      check("busy_during_calc", 32'(bad), 0);
      check("rsp_valid_seen", 32'(rsp_valid), 1);
      check("latency", lat, exp_lat(ey));
      check("rsp_p", 32'(rsp_p), 32'(ep));
      check("rsp_id", 32'(rsp_id), g);
      hold_p  = rsp_p;
      hold_id = rsp_id;
      bad = 0;
      for (int s = 0; s < stall; s++) begin
         @(negedge sclk);
         if (rsp_valid !== 1'b1 || rsp_p !== hold_p || rsp_id !== hold_id ||
             req_ready !== '0 || busy !== 1'b1) bad = 1;
      end
      if (stall > 0) begin
         check("backpressure_hold", 32'(bad), 0);
         rsp_ready = 1'b1;
      end
      @(negedge sclk);
      check("rsp_valid_drop", 32'(rsp_valid), 0);
      gid = g;
      gp  = hold_p;
   endtask

   typedef struct {
      int              ch;
      logic [DW-1:0]   x;
      logic [DW-1:0]   y;
      logic [2*DW-1:0] p;
   } vec_t;

   vec_t tbl[6];
   int   rr_ids[5];
   logic [2*DW-1:0] rr_ps[5];

   initial begin
      int gid;
      logic [2*DW-1:0] gp;
      bit bad;

      tbl[0] = '{ch: 0, x: 8'd13,  y: 8'd11,  p: 16'd143};
      tbl[1] = '{ch: 2, x: 8'hFF,  y: 8'hFF,  p: 16'hFE01};
      tbl[2] = '{ch: 1, x: 8'd0,   y: 8'd77,  p: 16'd0};
      tbl[3] = '{ch: 3, x: 8'd200, y: 8'd3,   p: 16'd600};
      tbl[4] = '{ch: 0, x: 8'd200, y: 8'h80,  p: 16'd25600};
      tbl[5] = '{ch: 3, x: 8'd1,   y: 8'd0,   p: 16'd0};
      rr_ids = '{0, 1, 2, 3, 0};
      rr_ps  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10};

      // Reset state
      repeat (2) @(negedge sclk);
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_rsp_p", 32'(rsp_p), 0);
      check("reset_rsp_id", 32'(rsp_id), 0);
      check("reset_req_ready", 32'(req_ready), 0);
      s_rst_n = 1'b1;
      model_rr = 0;
      @(negedge sclk);

      // Directed vectors, one requester at a time
      for (int i = 0; i < 6; i++) begin
         req_valid = '0;
         req_valid[tbl[i].ch] = 1'b1;
         req_x[tbl[i].ch*DW +: DW] = tbl[i].x;
         req_y[tbl[i].ch*DW +: DW] = tbl[i].y;
         run_op(0, 1, gid, gp);
         check("tbl_p", 32'(gp), 32'(tbl[i].p));
         check("tbl_id", gid, tbl[i].ch);
      end

      // Backpressure with a second requester waiting
      req_valid = 4'b0110;
      req_x[1*DW +: DW] = 8'd21; req_y[1*DW +: DW] = 8'd9;
      req_x[2*DW +: DW] = 8'd33; req_y[2*DW +: DW] = 8'd7;
      run_op(5, 1, gid, gp);
      run_op(0, 1, gid, gp);
      req_valid = '0;

      // Reset in the middle of CALC
      req_valid = 4'b0010;
      req_x[1*DW +: DW] = 8'd50; req_y[1*DW +: DW] = 8'd201;
      @(posedge sclk);
      @(negedge sclk);
      req_valid = '0;
      repeat (3) @(negedge sclk);
      check("midop_busy", 32'(busy), 1);
      s_rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_rsp_p", 32'(rsp_p), 0);
      check("midrst_rsp_id", 32'(rsp_id), 0);
      check("midrst_req_ready", 32'(req_ready), 0);
      @(negedge sclk);
      s_rst_n = 1'b1;
      model_rr = 0;
      bad = 0;
      repeat (20) begin
         @(negedge sclk);
         if (rsp_valid !== 1'b0) bad = 1;
      end
      check("no_rsp_after_reset", 32'(bad), 0);
      req_valid = 4'b1001;
      req_x[0*DW +: DW] = 8'd4; req_y[0*DW +: DW] = 8'd5;
      req_x[3*DW +: DW] = 8'd6; req_y[3*DW +: DW] = 8'd7;
      run_op(0, 1, gid, gp);
      check("post_reset_grant", gid, 0);
      run_op(0, 1, gid, gp);
      req_valid = '0;

      // All four valid continuously: rotation 0,1,2,3,0
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_x[i*DW +: DW] = DW'(i + 1);
         req_y[i*DW +: DW] = 8'd10;
      end
      req_valid = '1;
      for (int n = 0; n < 5; n++) begin
         run_op(0, 0, gid, gp);
         check("rr_id", gid, rr_ids[n]);
         check("rr_p", 32'(gp), 32'(rr_ps[n]));
      end
      req_valid = '0;

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*DW +: DW] = DW'($urandom);
            req_y[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 7))
                                                             : DW'($urandom);
         end
         req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         run_op($urandom_range(0, 3), bit'($urandom_range(0, 1)), gid, gp);
      end
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one sequential unsigned shift-add multiplier core among NUM_REQ requesters.
- Round-robin arbitration; a valid/ready handshake on each request channel and on the single response channel.
- The core is instantiated inside this block. Each response carries the ID of the requester that issued it.
- Sits between several DSP/control clients and the multiplier resource.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
DW, 8, operand width; product width is 2*DW
IDW, 2, requester-ID width, equal to clog2(NUM_REQ)

Ports:
sclk  in  1  system clock, all logic on rising edge
s_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_x  in  NUM_REQ*DW  packed multiplicands, channel i at [i*DW +: DW]
req_y  in  NUM_REQ*DW  packed multipliers, same packing
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accepts product
rsp_p  out  2*DW  unsigned product
rsp_id  out  IDW  index of the requester that issued the product
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, s_rst_n=0):
  - FSM goes to IDLE; round-robin pointer rr_ptr=0.
  - All of these clear to 0: rsp_valid, rsp_p, rsp_id, busy, internal x_reg/y_reg/acc/count.
  - Reset mid-operation discards the product in progress. No response is ever issued for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. req_ready is 0 in every other state.
  - On accept (req_valid & req_ready):
    - x_reg = zero-extended req_x[grant] (2*DW bits); y_reg = req_y[grant]; acc=0; count=0.
    - Store grant as tag; rr_ptr = (grant+1) mod NUM_REQ; go to CALC.
  - If no req_valid is set: stay in IDLE; rr_ptr is unchanged.
- CALC (one partial product per cycle):
  - If y_reg[0]=1 then acc = acc + x_reg.
  - Then x_reg shifts left 1, y_reg shifts right 1, count increments.
  - After exactly DW CALC cycles (count reaches DW-1 on the last one), go to DONE.
  - rsp_p = final acc and rsp_id = tag are loaded on the CALC->DONE edge. rsp_valid=1 from that edge.
- DONE:
  - rsp_valid=1; rsp_p and rsp_id are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0 on the next edge; go to IDLE.
- Latency: an accept at edge T gives rsp_valid=1 after edge T+DW.
- Throughput: at most one op per DW+2 cycles when rsp_ready is tied high.
- Arithmetic:
  - Unsigned only. acc is 2*DW bits and cannot overflow, since (2^DW-1)^2 < 2^(2*DW).
  - Operands 0 are legal and give 0.
- Boundary conditions:
  - All requesters valid continuously: grants rotate 0,1,2,3,0... No starvation; any waiting requester is served within NUM_REQ ops.
  - A requester that deasserts req_valid before it is granted loses nothing; no ready was given.
  - req_x/req_y are sampled only on the accept edge and may change afterwards.
  - rsp_ready=1 while rsp_valid=0 is ignored.
  - A new request can be accepted in the IDLE cycle right after the response handshake. There is no accept in the same cycle as that handshake.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In CALC, when the y_reg value after the shift is 0, the FSM moves to DONE at that edge. rsp_p holds acc including that cycle's addition.
  - An operand y=0 leaves CALC after 1 cycle.
  - Latency = max(1, index of the highest set bit of y + 1) CALC cycles.
  - The product value is identical to the non-early-termination result.
- Not defined: CALC always runs exactly DW cycles regardless of operand values.

Test Plan:
- Single request, ch0 x=8'd13 y=8'd11, rsp_ready=1 -> rsp_p=16'd143, rsp_id=0, rsp_valid 8 cycles after accept (no EN); busy high throughout.
- Max operands, ch2 x=8'hFF y=8'hFF -> rsp_p=16'hFE01, rsp_id=2; zero case ch1 x=8'd0 y=8'd77 -> rsp_p=0, rsp_id=1.
- All four valid continuously with distinct operands (ch i: x=i+1, y=10) -> responses in order id 0,1,2,3,0 with rsp_p=10,20,30,40,10; only one req_ready bit high per accept.
- Backpressure, rsp_ready=0 for 5 cycles after rsp_valid -> rsp_p/rsp_id stable, req_ready all 0 while waiting; a new accept only after the handshake.
- Reset asserted at CALC cycle 4 -> all outputs 0 immediately, no rsp_valid afterwards; the next request goes to ch0 priority (rr_ptr=0).
- MULT_EARLY_TERM_EN, x=8'd200 y=8'd3 -> rsp_p=16'd600 after 2 CALC cycles; y=8'h80 -> 8 CALC cycles, rsp_p=16'd25600.
